core_done_controller: RTL and testbench
=======================================

CORE_DONE_CONTROLLER -- requirements
Module: core_done_controller

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, meaning number of monitored cores (1..64).
REQ-002 SHALL have parameter RST_STAGES, default 6, meaning core-reset pipeline depth (>=1).
REQ-003 SHALL have parameter ADDR_WIDTH, default 14, meaning dmem address width per core.
REQ-004 SHALL have parameter DONE_MODE, default 0, meaning 0 = any store signals done, 1 = store to DONE_ADDR with nonzero data.
REQ-005 SHALL have parameter DONE_ADDR, default 'h3FF, meaning done mailbox word address (DONE_MODE=1 only).
REQ-006 SHALL have parameter CNT_WIDTH, default 32, meaning run-cycle counter width.
REQ-007 SHALL have parameter LED_BLINK, default 0, meaning 0 = steady LED, 1 = blinking LED.
REQ-008 SHALL have parameter BLINK_LOG2, default 24, meaning LED toggles every 2^BLINK_LOG2 cycles.
REQ-009 SHALL have ports: clk  in  1  sole clock; reset  in  1  asynchronous, active-high block reset.
REQ-010 SHALL have port i_proc_rst  in  1  synchronised processor reset request.
REQ-011 SHALL have port i_dmem_wr_en  in  4*NUM_CORES  per-core byte write enables, core k at [4k+3:4k].
REQ-012 SHALL have port i_dmem_addr  in  ADDR_WIDTH*NUM_CORES  per-core store address.
REQ-013 SHALL have port i_dmem_wr_data  in  32*NUM_CORES  per-core store data.
REQ-014 SHALL have port o_core_reset  out  1  pipelined reset to all cores.
REQ-015 SHALL have ports o_done_vec  out  NUM_CORES  sticky per-core done; o_all_done  out  1.
REQ-016 SHALL have ports o_cycle_count  out  CNT_WIDTH; o_count_valid  out  1; o_overflow  out  1; o_done_led  out  1.

Function
REQ-017 SHALL delay i_proc_rst through RST_STAGES registers to o_core_reset; all stages set to 1 by reset.
REQ-018 SHALL implement FSM states HOLD, RUN, DONE.
REQ-019 HOLD -> RUN on first edge where o_core_reset is 0; RUN -> DONE on edge where o_all_done goes 1.
REQ-020 Any state -> HOLD whenever o_core_reset is 1; clears o_done_vec, o_all_done, o_cycle_count, o_count_valid, o_overflow.
REQ-021 Done event core k, DONE_MODE=0: |wr_en_k. DONE_MODE=1: |wr_en_k AND addr_k==DONE_ADDR AND data_k!=0.
REQ-022 Done events SHALL be sampled only in RUN; o_done_vec[k] sets on the edge after the event, stays set until HOLD.
REQ-023 o_all_done SHALL be registered &o_done_vec, i.e. one cycle after the last bit sets.
REQ-024 o_cycle_count SHALL increment by 1 per RUN edge starting at 0; freeze in DONE; o_count_valid=1 in DONE only.
REQ-025 Counter SHALL saturate at all-ones and set sticky o_overflow; no wrap.
REQ-026 Simultaneous done events from multiple cores SHALL all be captured on the same edge.
REQ-027 o_core_reset=1 and a done event on the same edge: reset wins, event discarded.
REQ-028 o_done_led: LED_BLINK=0 -> equals o_all_done; LED_BLINK=1 -> 0 outside DONE, toggles every 2^BLINK_LOG2 cycles in DONE, starting 1.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 On reset: pipeline all 1s, o_core_reset=1, state HOLD, o_done_vec=0, o_all_done=0, o_cycle_count=0, o_count_valid=0, o_overflow=0, o_done_led=0, blink counter 0.
REQ-031 Reset assertion SHALL take effect immediately, without clk; deassertion is synchronous to the following edges.

Verification
REQ-032 Release reset, i_proc_rst=0, RST_STAGES=6 -> o_core_reset 1 for exactly 6 edges then 0; RUN; count 0,1,2...
REQ-033 NUM_CORES=4, mode 0: core 2 wr_en=4'b0001 -> o_done_vec=4'b0100 next edge; cores 0,1,3 later -> o_all_done one edge after last, count frozen, o_count_valid=1.
REQ-034 Mode 1, DONE_ADDR='h3FF: store to 'h3FE ignored; store to 'h3FF data 0 ignored; data 1 -> done bit set.
REQ-035 i_proc_rst pulsed in DONE -> o_core_reset high 6 edges later, all status cleared same edge; re-run counts from 0.
REQ-036 All 4 cores store on the same edge -> o_done_vec=4'hF in one edge, o_all_done next edge.
REQ-037 CNT_WIDTH=4, no done for 20 RUN cycles -> count holds 15, o_overflow=1; LED_BLINK=1, BLINK_LOG2=2 -> LED toggles every 4 cycles in DONE.

Source files
------------

// File: rtl/core_done_controller.sv
// Pipelines the processor reset out to the cores and tracks per-core completion,
// the run-cycle count and a done LED for a multi-core array.
module core_done_controller #(
  parameter int NUM_CORES  = 4,
  parameter int RST_STAGES = 6,
  parameter int ADDR_WIDTH = 14,
  parameter int DONE_MODE  = 0,
  parameter int DONE_ADDR  = 32'h0000_03FF,
  parameter int CNT_WIDTH  = 32,
  parameter int LED_BLINK  = 0,
  parameter int BLINK_LOG2 = 24
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_proc_rst,
  input  logic [4*NUM_CORES-1:0]          i_dmem_wr_en,
  input  logic [ADDR_WIDTH*NUM_CORES-1:0] i_dmem_addr,
  input  logic [32*NUM_CORES-1:0]         i_dmem_wr_data,
  output logic                            o_core_reset,
  output logic [NUM_CORES-1:0]            o_done_vec,
  output logic                            o_all_done,
  output logic [CNT_WIDTH-1:0]            o_cycle_count,
  output logic                            o_count_valid,
  output logic                            o_overflow,
  output logic                            o_done_led
);

  localparam logic [ADDR_WIDTH-1:0] DONE_ADDR_L = ADDR_WIDTH'(DONE_ADDR);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [RST_STAGES-1:0]   rst_pipe_r;
  logic [RST_STAGES-1:0]   rst_pipe_nxt_s;
  logic                    core_rst_nxt_s;
  logic [NUM_CORES-1:0]    done_evt_s;
  logic [NUM_CORES-1:0]    done_vec_r;
  logic                    all_done_r;
  logic [CNT_WIDTH-1:0]    cnt_r;
  logic                    cnt_valid_r;
  logic                    ovf_r;
  logic                    led_r;
  logic [BLINK_LOG2-1:0]   blink_r;

  // Next value of the reset shift pipeline.
  always_comb begin
    rst_pipe_nxt_s    = {RST_STAGES{1'b0}};
    rst_pipe_nxt_s[0] = i_proc_rst;
    for (int i = 1; i < RST_STAGES; i++) begin
      rst_pipe_nxt_s[i] = rst_pipe_r[i-1];
    end
  end

  // Status clears on the same edge the core reset rises, so key off the next value.
  assign core_rst_nxt_s = rst_pipe_nxt_s[RST_STAGES-1];

  // Reset pipeline register; every stage powers up asserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_pipe_r <= {RST_STAGES{1'b1}};
    end else begin
      rst_pipe_r <= rst_pipe_nxt_s;
    end
  end

  // Per-core done event decode from the data-memory store port.
  always_comb begin
    done_evt_s = {NUM_CORES{1'b0}};
    for (int k = 0; k < NUM_CORES; k++) begin
      if (DONE_MODE == 0) begin
        done_evt_s[k] = |i_dmem_wr_en[4*k +: 4];
      end else begin
        done_evt_s[k] = (|i_dmem_wr_en[4*k +: 4]) &&
                        (i_dmem_addr[ADDR_WIDTH*k +: ADDR_WIDTH] == DONE_ADDR_L) &&
                        (i_dmem_wr_data[32*k +: 32] != 32'd0);
      end
    end
  end

  // Next-state logic for the HOLD/RUN/DONE controller.
  always_comb begin
    state_nxt_s = state_r;
    if (core_rst_nxt_s) begin
      state_nxt_s = ST_HOLD;
    end else begin
      case (state_r)
        ST_HOLD: state_nxt_s = ST_RUN;
        ST_RUN: begin
          if (&done_vec_r) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_DONE: state_nxt_s = ST_DONE;
        default: state_nxt_s = ST_HOLD;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_HOLD;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Done capture, all-done flag and saturating run counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_vec_r  <= {NUM_CORES{1'b0}};
      all_done_r  <= 1'b0;
      cnt_r       <= {CNT_WIDTH{1'b0}};
      cnt_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
    end else if (core_rst_nxt_s) begin
      done_vec_r  <= {NUM_CORES{1'b0}};
      all_done_r  <= 1'b0;
      cnt_r       <= {CNT_WIDTH{1'b0}};
      cnt_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
    end else if (state_r == ST_RUN) begin
      done_vec_r  <= done_vec_r | done_evt_s;
      all_done_r  <= &done_vec_r;
      cnt_valid_r <= &done_vec_r;
      if (cnt_r == {CNT_WIDTH{1'b1}}) begin
        ovf_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r + CNT_WIDTH'(1);
      end
    end else begin
      done_vec_r  <= done_vec_r;
      all_done_r  <= all_done_r;
      cnt_valid_r <= cnt_valid_r;
    end
  end

  // Done LED: steady copy of all-done, or a blink that starts lit on entry to DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_r   <= 1'b0;
      blink_r <= {BLINK_LOG2{1'b0}};
    end else if (state_nxt_s != ST_DONE) begin
      led_r   <= 1'b0;
      blink_r <= {BLINK_LOG2{1'b0}};
    end else if (LED_BLINK == 0) begin
      led_r   <= 1'b1;
      blink_r <= {BLINK_LOG2{1'b0}};
    end else if (state_r != ST_DONE) begin
      led_r   <= 1'b1;
      blink_r <= {BLINK_LOG2{1'b0}};
    end else begin
      blink_r <= blink_r + BLINK_LOG2'(1);
      if (blink_r == {BLINK_LOG2{1'b1}}) begin
        led_r <= ~led_r;
      end
    end
  end

  assign o_core_reset  = rst_pipe_r[RST_STAGES-1];
  assign o_done_vec    = done_vec_r;
  assign o_all_done    = all_done_r;
  assign o_cycle_count = cnt_r;
  assign o_count_valid = cnt_valid_r;
  assign o_overflow    = ovf_r;
  assign o_done_led    = led_r;

endmodule

// File: tb/tb_core_done_controller.sv
// Randomized bench for core_done_controller: two instances (mode 0 / defaults, and
// mode 1 with a 4-bit counter and blinking LED) checked against a behavioural model.
module tb_core_done_controller;

  localparam int NC = 4;
  localparam int AW = 14;

  logic clk = 1'b0;
  logic reset;
  logic proc_rst0, proc_rst1;
  logic [4*NC-1:0]  we0, we1;
  logic [AW*NC-1:0] ad0, ad1;
  logic [32*NC-1:0] wd0, wd1;

  logic        cr0, ald0, val0, ovf0, led0;
  logic [3:0]  dv0;
  logic [31:0] cnt0;
  logic        cr1, ald1, val1, ovf1, led1;
  logic [3:0]  dv1;
  logic [3:0]  cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  core_done_controller #(.NUM_CORES(NC)) u_dut0 (
    .clk(clk), .reset(reset), .i_proc_rst(proc_rst0),
    .i_dmem_wr_en(we0), .i_dmem_addr(ad0), .i_dmem_wr_data(wd0),
    .o_core_reset(cr0), .o_done_vec(dv0), .o_all_done(ald0),
    .o_cycle_count(cnt0), .o_count_valid(val0), .o_overflow(ovf0), .o_done_led(led0)
  );

  core_done_controller #(
    .NUM_CORES(NC), .RST_STAGES(3), .ADDR_WIDTH(AW), .DONE_MODE(1),
    .DONE_ADDR(32'h3FF), .CNT_WIDTH(4), .LED_BLINK(1), .BLINK_LOG2(2)
  ) u_dut1 (
    .clk(clk), .reset(reset), .i_proc_rst(proc_rst1),
    .i_dmem_wr_en(we1), .i_dmem_addr(ad1), .i_dmem_wr_data(wd1),
    .o_core_reset(cr1), .o_done_vec(dv1), .o_all_done(ald1),
    .o_cycle_count(cnt1), .o_count_valid(val1), .o_overflow(ovf1), .o_done_led(led1)
  );

  // ---------------- behavioural reference model ----------------
  // phase: 0 = held in reset, 1 = running, 2 = finished
  bit     q0[$];
  bit     q1[$];
  int     stages[2]   = '{6, 3};
  longint cnt_max[2]  = '{64'hFFFF_FFFF, 64'd15};
  bit     blinks[2]   = '{1'b0, 1'b1};
  int     m_phase[2];
  bit     m_cr[2], m_all[2], m_valid[2], m_ovf[2], m_led[2];
  bit [3:0] m_done[2];
  longint m_cnt[2];
  int     m_bk[2];

  function automatic void model_reset();
    q0.delete();
    q1.delete();
    for (int i = 0; i < stages[0] - 1; i++) q0.push_back(1'b1);
    for (int i = 0; i < stages[1] - 1; i++) q1.push_back(1'b1);
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0; m_cr[d] = 1'b1; m_all[d] = 1'b0; m_valid[d] = 1'b0;
      m_ovf[d] = 1'b0; m_led[d] = 1'b0; m_done[d] = 4'd0; m_cnt[d] = 0; m_bk[d] = 0;
    end
  endfunction

  // A core reports done: mode 0 on any store, mode 1 on a nonzero store to the mailbox.
  function automatic bit [3:0] events(int d);
    bit [3:0] ev;
    for (int k = 0; k < NC; k++) begin
      if (d == 0) ev[k] = (we0[4*k +: 4] != 4'd0);
      else        ev[k] = (we1[4*k +: 4] != 4'd0) && (ad1[AW*k +: AW] == 14'h3FF) &&
                          (wd1[32*k +: 32] != 32'd0);
    end
    return ev;
  endfunction

  function automatic void model_edge(int d, bit prst, bit [3:0] ev);
    bit cr;
    bit was_all;
    if (d == 0) begin q0.push_back(prst); cr = q0.pop_front(); end
    else        begin q1.push_back(prst); cr = q1.pop_front(); end
    m_cr[d] = cr;
    if (cr) begin
      m_phase[d] = 0; m_all[d] = 1'b0; m_valid[d] = 1'b0; m_ovf[d] = 1'b0;
      m_led[d] = 1'b0; m_done[d] = 4'd0; m_cnt[d] = 0; m_bk[d] = 0;
    end else if (m_phase[d] == 0) begin
      m_phase[d] = 1;
    end else if (m_phase[d] == 1) begin
      was_all = (m_done[d] == 4'hF);
      m_done[d] = m_done[d] | ev;
      if (m_cnt[d] == cnt_max[d]) m_ovf[d] = 1'b1;
      else m_cnt[d] = m_cnt[d] + 1;
      if (was_all) begin
        m_phase[d] = 2; m_all[d] = 1'b1; m_valid[d] = 1'b1; m_led[d] = 1'b1; m_bk[d] = 0;
      end
    end else if (blinks[d]) begin
      m_bk[d] = m_bk[d] + 1;
      if (m_bk[d] == 4) begin m_bk[d] = 0; m_led[d] = ~m_led[d]; end
    end
  endfunction

  function automatic logic [40:0] exp_pack(int d);
    return {m_cr[d], m_done[d], m_all[d], m_valid[d], m_ovf[d], m_led[d], 32'(m_cnt[d])};
  endfunction

  function automatic logic [40:0] obs(int d);
    if (d == 0) return {cr0, dv0, ald0, val0, ovf0, led0, cnt0};
    return {cr1, dv1, ald1, val1, ovf1, led1, 28'd0, cnt1};
  endfunction

  // Advance one clock; model sees the inputs the DUTs sample, outputs read at +1.
  task automatic step();
    bit [3:0] e0, e1;
    @(posedge clk);
    e0 = events(0);
    e1 = events(1);
    if (reset) model_reset();
    else begin
      model_edge(0, proc_rst0, e0);
      model_edge(1, proc_rst1, e1);
    end
    #1;
  endtask

  task automatic idle0();
    we0 = '0; ad0 = '0; wd0 = '0;
  endtask

  task automatic idle1();
    we1 = '0; ad1 = '0; wd1 = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; proc_rst0 = 1'b0; proc_rst1 = 1'b0; idle0(); idle1();
    model_reset();
    #2;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs(d) !== exp_pack(d)) begin
        errors++; $display("FAIL reset_async d%0d got %h exp %h", d, obs(d), exp_pack(d));
      end
    end
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_startup();
    for (int i = 0; i < 10; i++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs(d) !== exp_pack(d)) begin
          errors++; $display("FAIL startup d%0d cyc %0d got %h exp %h", d, i, obs(d), exp_pack(d));
        end
      end
    end
    checks++;
    if (cnt0 !== 32'd4) begin
      errors++; $display("FAIL startup_count got %0d exp 4", cnt0);
    end
  endtask

  task automatic test_single_core();
    bit [3:0] order[4] = '{4'd2, 4'd0, 4'd1, 4'd3};
    for (int j = 0; j < 4; j++) begin
      idle0();
      we0[4*order[j] +: 4] = 4'b0001;
      step();
      idle0();
      if (j == 0) begin
        checks++;
        if (dv0 !== 4'b0100) begin
          errors++; $display("FAIL core2_done got %b exp 0100", dv0);
        end
      end
      for (int i = 0; i < 3; i++) begin
        step();
        checks++;
        if (obs(0) !== exp_pack(0)) begin
          errors++; $display("FAIL single_core step %0d.%0d got %h exp %h", j, i, obs(0), exp_pack(0));
        end
      end
    end
    checks++;
    if ({ald0, val0} !== 2'b11) begin
      errors++; $display("FAIL single_core_done got %b exp 11", {ald0, val0});
    end
  endtask

  task automatic test_rerun();
    proc_rst0 = 1'b1;
    step();
    proc_rst0 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (obs(0) !== exp_pack(0)) begin
        errors++; $display("FAIL rerun cyc %0d got %h exp %h", i, obs(0), exp_pack(0));
      end
    end
  endtask

  task automatic test_simultaneous();
    we0 = 16'h8421;
    step();
    idle0();
    checks++;
    if (dv0 !== 4'hF || ald0 !== 1'b0) begin
      errors++; $display("FAIL simul_vec got %h/%b exp f/0", dv0, ald0);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs(0) !== exp_pack(0)) begin
        errors++; $display("FAIL simultaneous cyc %0d got %h exp %h", i, obs(0), exp_pack(0));
      end
    end
  endtask

  task automatic test_mode1();
    proc_rst1 = 1'b1;
    step();
    proc_rst1 = 1'b0;
    for (int i = 0; i < 4; i++) step();
    // wrong address, zero data, then a valid mailbox store on core 2
    idle1(); we1[3:0] = 4'hF; ad1[AW-1:0] = 14'h3FE; wd1[31:0] = 32'd1;
    we1[7:4] = 4'h1; ad1[2*AW-1:AW] = 14'h3FF; wd1[63:32] = 32'd0;
    we1[11:8] = 4'h8; ad1[3*AW-1:2*AW] = 14'h3FF; wd1[95:64] = 32'd1;
    step();
    idle1();
    checks++;
    if (dv1 !== 4'b0100) begin
      errors++; $display("FAIL mode1_filter got %b exp 0100", dv1);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs(1) !== exp_pack(1)) begin
        errors++; $display("FAIL mode1 cyc %0d got %h exp %h", i, obs(1), exp_pack(1));
      end
    end
  endtask

  task automatic test_overflow_blink();
    proc_rst1 = 1'b1;
    step();
    proc_rst1 = 1'b0;
    idle1();
    for (int i = 0; i < 23; i++) step();
    checks++;
    if (cnt1 !== 4'd15 || ovf1 !== 1'b1) begin
      errors++; $display("FAIL overflow got %0d/%b exp 15/1", cnt1, ovf1);
    end
    we1 = 16'hFFFF;
    for (int k = 0; k < NC; k++) begin
      ad1[AW*k +: AW] = 14'h3FF; wd1[32*k +: 32] = 32'h1 + 32'(k);
    end
    step();
    idle1();
    for (int i = 0; i < 14; i++) begin
      step();
      checks++;
      if (obs(1) !== exp_pack(1)) begin
        errors++; $display("FAIL blink cyc %0d got %h exp %h", i, obs(1), exp_pack(1));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      proc_rst0 = ($urandom_range(0, 70) == 0);
      proc_rst1 = ($urandom_range(0, 70) == 0);
      for (int k = 0; k < NC; k++) begin
        we0[4*k +: 4] = ($urandom_range(0, 12) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        ad0[AW*k +: AW] = 14'($urandom);
        wd0[32*k +: 32] = $urandom;
        we1[4*k +: 4] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        case ($urandom_range(0, 3))
          0: ad1[AW*k +: AW] = 14'h3FF;
          1: ad1[AW*k +: AW] = 14'h3FE;
          default: ad1[AW*k +: AW] = 14'($urandom);
        endcase
        case ($urandom_range(0, 2))
          0: wd1[32*k +: 32] = 32'd0;
          1: wd1[32*k +: 32] = 32'd1;
          default: wd1[32*k +: 32] = $urandom;
        endcase
      end
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs(d) !== exp_pack(d)) begin
          errors++; $display("FAIL random d%0d cyc %0d got %h exp %h", d, i, obs(d), exp_pack(d));
        end
      end
    end
    proc_rst0 = 1'b0; proc_rst1 = 1'b0; idle0(); idle1();
  endtask

  task automatic test_async_midrun();
    for (int i = 0; i < 8; i++) step();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs(d) !== exp_pack(d)) begin
        errors++; $display("FAIL async_midrun d%0d got %h exp %h", d, obs(d), exp_pack(d));
      end
    end
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs(d) !== exp_pack(d)) begin
          errors++; $display("FAIL after_async d%0d cyc %0d got %h exp %h", d, i, obs(d), exp_pack(d));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_single_core();
    test_rerun();
    test_simultaneous();
    test_mode1();
    test_overflow_blink();
    test_random();
    test_async_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
